// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared states and constants for the SNN inference controller
package snn_pkg;

    localparam int NUM_CH    = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DRIVE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/snn_argmax3.sv
// rtl/snn_argmax3.sv - three-way argmax of spike counts, ties go to the lowest index
module snn_argmax3
#(
    parameter int CNT_W = snn_pkg::CNT_W_DEF
) (
    input  logic [CNT_W-1:0] i_cnt0,
    input  logic [CNT_W-1:0] i_cnt1,
    input  logic [CNT_W-1:0] i_cnt2,
    output logic [1:0]       o_idx
);

    logic [CNT_W-1:0] best;

    // Strict greater-than keeps the earlier index on equal counts.
    always_comb begin
        o_idx = 2'd0;
        best  = i_cnt0;
        if (i_cnt1 > best) begin
            o_idx = 2'd1;
            best  = i_cnt1;
        end
        if (i_cnt2 > best) begin
            o_idx = 2'd2;
        end
    end

endmodule

// File: rtl/snn_infer_ctrl.sv
// rtl/snn_infer_ctrl.sv - sequences one SNN inference: clear, drive, drain, count and classify
module snn_infer_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int PIPE_LAT  = 4,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    input  logic [7:0]       i_data0,
    input  logic [7:0]       i_data1,
    input  logic [7:0]       i_data2,
    output logic             o_ready,
    output logic             o_net_rstn,
    output logic [7:0]       o_net_data0,
    output logic [7:0]       o_net_data1,
    output logic [7:0]       o_net_data2,
    input  logic [7:0]       i_net_data0,
    input  logic [7:0]       i_net_data1,
    input  logic [7:0]       i_net_data2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_class,
    output logic [CNT_W-1:0] o_count0,
    output logic [CNT_W-1:0] o_count1,
    output logic [CNT_W-1:0] o_count2
);

    // One step counter spans DRIVE and DRAIN; the count window is its tail.
    localparam int STEP_TOTAL = NUM_STEPS + PIPE_LAT;
    localparam int STEP_W     = $clog2(STEP_TOTAL + 1);

    localparam logic [STEP_W-1:0] DRIVE_LAST = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(STEP_TOTAL - 1);
    localparam logic [STEP_W-1:0] WIN_FIRST  = STEP_W'(PIPE_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        sample_q [NUM_CH];
    logic [7:0]        sample_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [1:0]        class_q, class_d;
    logic              net_rstn_q, net_rstn_d;

    logic [7:0]        in_data  [NUM_CH];
    logic [7:0]        net_out  [NUM_CH];
    logic              accept;
    logic              in_window;
    logic [1:0]        win_idx;

    assign in_data[0] = i_data0;
    assign in_data[1] = i_data1;
    assign in_data[2] = i_data2;
    assign net_out[0] = i_net_data0;
    assign net_out[1] = i_net_data1;
    assign net_out[2] = i_net_data2;

    // Window opens PIPE_LAT steps after the first DRIVE cycle and runs to the end of DRAIN.
    assign in_window = ((state_q == DRIVE) || (state_q == DRAIN)) && (step_q >= WIN_FIRST);

    // Next-state logic and the sample latch.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        sample_d = sample_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    accept   = 1'b1;
                    sample_d = in_data;
                    step_d   = '0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                step_d  = '0;
                state_d = DRIVE;
            end
            DRIVE: begin
                step_d = step_q + 1'b1;
                if (step_q == DRIVE_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                step_d = step_q + 1'b1;
                if (step_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-output saturating spike counters, cleared on accept.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept) begin
                cnt_d[i] = '0;
            end else if (in_window && (net_out[i] != 8'd0) && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    snn_argmax3 #(
        .CNT_W (CNT_W)
    ) u_argmax (
        .i_cnt0 (cnt_d[0]),
        .i_cnt1 (cnt_d[1]),
        .i_cnt2 (cnt_d[2]),
        .o_idx  (win_idx)
    );

    // Class is captured from the final counts as the FSM enters DONE; net clear is low only through CLEAR.
    always_comb begin
        class_d    = class_q;
        net_rstn_d = (state_d != CLEAR);
        if ((state_d == DONE) && (state_q != DONE)) begin
            class_d = win_idx;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            step_q     <= '0;
            class_q    <= 2'd0;
            net_rstn_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sample_q[i] <= 8'd0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            class_q    <= class_d;
            net_rstn_q <= net_rstn_d;
            for (int i = 0; i < NUM_CH; i++) begin
                sample_q[i] <= sample_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_net_rstn  = net_rstn_q;
    assign o_net_data0 = (state_q == DRIVE) ? sample_q[0] : 8'd0;
    assign o_net_data1 = (state_q == DRIVE) ? sample_q[1] : 8'd0;
    assign o_net_data2 = (state_q == DRIVE) ? sample_q[2] : 8'd0;
    assign o_class     = class_q;
    assign o_count0    = cnt_q[0];
    assign o_count1    = cnt_q[1];
    assign o_count2    = cnt_q[2];

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// tb/tb_snn_infer_ctrl.sv - directed self-checking bench for snn_infer_ctrl
module tb_snn_infer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic       a_i_valid, a_i_ready;
    logic [7:0] a_i_data0, a_i_data1, a_i_data2;
    logic [7:0] a_i_net_data0, a_i_net_data1, a_i_net_data2;
    logic       a_o_ready, a_o_net_rstn, a_o_valid;
    logic [7:0] a_o_net_data0, a_o_net_data1, a_o_net_data2;
    logic [1:0] a_o_class;
    logic [7:0] a_o_count0, a_o_count1, a_o_count2;

    logic       s_i_valid, s_i_ready;
    logic [7:0] s_i_data0, s_i_data1, s_i_data2;
    logic [7:0] s_i_net_data0, s_i_net_data1, s_i_net_data2;
    logic       s_o_ready, s_o_net_rstn, s_o_valid;
    logic [7:0] s_o_net_data0, s_o_net_data1, s_o_net_data2;
    logic [1:0] s_o_class;
    logic [3:0] s_o_count0, s_o_count1, s_o_count2;

    snn_infer_ctrl dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_valid(a_i_valid),
        .i_data0(a_i_data0), .i_data1(a_i_data1), .i_data2(a_i_data2),
        .o_ready(a_o_ready), .o_net_rstn(a_o_net_rstn),
        .o_net_data0(a_o_net_data0), .o_net_data1(a_o_net_data1), .o_net_data2(a_o_net_data2),
        .i_net_data0(a_i_net_data0), .i_net_data1(a_i_net_data1), .i_net_data2(a_i_net_data2),
        .o_valid(a_o_valid), .i_ready(a_i_ready), .o_class(a_o_class),
        .o_count0(a_o_count0), .o_count1(a_o_count1), .o_count2(a_o_count2)
    );

    snn_infer_ctrl #(.NUM_STEPS(20), .PIPE_LAT(4), .CNT_W(4)) dut_s (
        .i_clk(clk), .i_rstn(rstn), .i_valid(s_i_valid),
        .i_data0(s_i_data0), .i_data1(s_i_data1), .i_data2(s_i_data2),
        .o_ready(s_o_ready), .o_net_rstn(s_o_net_rstn),
        .o_net_data0(s_o_net_data0), .o_net_data1(s_o_net_data1), .o_net_data2(s_o_net_data2),
        .i_net_data0(s_i_net_data0), .i_net_data1(s_i_net_data1), .i_net_data2(s_i_net_data2),
        .o_valid(s_o_valid), .i_ready(s_i_ready), .o_class(s_o_class),
        .o_count0(s_o_count0), .o_count1(s_o_count1), .o_count2(s_o_count2)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0]  pat       [0:63];
    logic [23:0] obs_nd    [0:63];
    logic        obs_nrstn [0:63];
    logic        obs_ready [0:63];
    int          done_k;

    task automatic clear_pat;
        for (int k = 0; k < 64; k++) pat[k] = 3'b000;
    endtask

    task automatic run_a(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input bit keep_valid);
        done_k = -1;
        @(negedge clk);
        a_i_valid = 1'b1;
        a_i_data0 = d0;
        a_i_data1 = d1;
        a_i_data2 = d2;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            obs_nd[k]    = {a_o_net_data0, a_o_net_data1, a_o_net_data2};
            obs_nrstn[k] = a_o_net_rstn;
            obs_ready[k] = a_o_ready;
            if (!keep_valid) a_i_valid = 1'b0;
            a_i_data0     = 8'(k * 7 + 3);
            a_i_data1     = 8'(k * 11);
            a_i_data2     = 8'(255 - k);
            a_i_net_data0 = pat[k][0] ? 8'(16 + k) : 8'h00;
            a_i_net_data1 = pat[k][1] ? 8'(16 + k) : 8'h00;
            a_i_net_data2 = pat[k][2] ? 8'(16 + k) : 8'h00;
            if (a_o_valid) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic handshake_a;
        a_i_ready = 1'b1;
        @(negedge clk);
        a_i_ready     = 1'b0;
        a_i_net_data0 = 8'h00;
        a_i_net_data1 = 8'h00;
        a_i_net_data2 = 8'h00;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        a_i_valid = 0; a_i_ready = 0; a_i_data0 = 0; a_i_data1 = 0; a_i_data2 = 0;
        a_i_net_data0 = 0; a_i_net_data1 = 0; a_i_net_data2 = 0;
        s_i_valid = 0; s_i_ready = 0; s_i_data0 = 0; s_i_data1 = 0; s_i_data2 = 0;
        s_i_net_data0 = 0; s_i_net_data1 = 0; s_i_net_data2 = 0;
        repeat (2) @(negedge clk);
        checks++; if (a_o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", a_o_ready); end
        checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", a_o_valid); end
        checks++; if (a_o_net_rstn !== 1'b0) begin errors++; $display("FAIL reset_net_rstn got %0b exp 0", a_o_net_rstn); end
        checks++; if ({a_o_net_data0, a_o_net_data1, a_o_net_data2} !== 24'h0) begin errors++; $display("FAIL reset_net_data got %0h exp 0", {a_o_net_data0, a_o_net_data1, a_o_net_data2}); end
        checks++; if (a_o_class !== 2'd0) begin errors++; $display("FAIL reset_class got %0d exp 0", a_o_class); end
        checks++; if ({a_o_count0, a_o_count1, a_o_count2} !== 24'h0) begin errors++; $display("FAIL reset_counts got %0h exp 0", {a_o_count0, a_o_count1, a_o_count2}); end
        checks++; if (s_o_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0b exp 1", s_o_ready); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (a_o_net_rstn !== 1'b1) begin errors++; $display("FAIL release_net_rstn got %0b exp 1", a_o_net_rstn); end
    endtask

    task automatic test_basic;
        clear_pat();
        for (int k = 0; k < 64; k++) pat[k][0] = 1'b1;
        run_a(8'd10, 8'd20, 8'd30, 1'b0);
        checks++; if (done_k != 22) begin errors++; $display("FAIL basic_latency got %0d exp 22", done_k); end
        checks++; if (a_o_count0 !== 8'd16) begin errors++; $display("FAIL basic_count0 got %0d exp 16", a_o_count0); end
        checks++; if (a_o_count1 !== 8'd0 || a_o_count2 !== 8'd0) begin errors++; $display("FAIL basic_count12 got %0d,%0d exp 0,0", a_o_count1, a_o_count2); end
        checks++; if (a_o_class !== 2'd0) begin errors++; $display("FAIL basic_class got %0d exp 0", a_o_class); end
        checks++; if (obs_ready[1] !== 1'b0) begin errors++; $display("FAIL basic_ready_busy got %0b exp 0", obs_ready[1]); end
        checks++; if (obs_nrstn[1] !== 1'b0 || obs_nrstn[2] !== 1'b1) begin errors++; $display("FAIL basic_net_rstn got %0b%0b exp 01", obs_nrstn[1], obs_nrstn[2]); end
        checks++; if (obs_nd[1] !== 24'h0) begin errors++; $display("FAIL basic_nd_clear got %0h exp 0", obs_nd[1]); end
        checks++; if (obs_nd[2] !== 24'h0a141e) begin errors++; $display("FAIL basic_nd_first got %0h exp a141e", obs_nd[2]); end
        checks++; if (obs_nd[17] !== 24'h0a141e) begin errors++; $display("FAIL basic_nd_last got %0h exp a141e", obs_nd[17]); end
        checks++; if (obs_nd[18] !== 24'h0) begin errors++; $display("FAIL basic_nd_drain got %0h exp 0", obs_nd[18]); end
        handshake_a();
        checks++; if (a_o_valid !== 1'b0 || a_o_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake got v%0b r%0b exp v0 r1", a_o_valid, a_o_ready); end
    endtask

    task automatic test_tie;
        clear_pat();
        for (int k = 2; k <= 5; k++) pat[k][0] = 1'b1;
        pat[6][1] = 1; pat[8][1] = 1; pat[10][1] = 1; pat[12][1] = 1; pat[14][1] = 1;
        pat[7][2] = 1; pat[9][2] = 1; pat[11][2] = 1; pat[13][2] = 1; pat[21][2] = 1;
        run_a(8'd1, 8'd2, 8'd3, 1'b0);
        checks++; if (done_k != 22) begin errors++; $display("FAIL tie_latency got %0d exp 22", done_k); end
        checks++; if ({a_o_count0, a_o_count1, a_o_count2} !== {8'd0, 8'd5, 8'd5}) begin errors++; $display("FAIL tie_counts got %0d,%0d,%0d exp 0,5,5", a_o_count0, a_o_count1, a_o_count2); end
        checks++; if (a_o_class !== 2'd1) begin errors++; $display("FAIL tie_class got %0d exp 1", a_o_class); end
        handshake_a();
    endtask

    task automatic test_window;
        clear_pat();
        pat[5][0] = 1; pat[22][0] = 1;
        pat[6][1] = 1; pat[21][1] = 1;
        pat[1][2] = 1;
        run_a(8'd5, 8'd6, 8'd7, 1'b0);
        @(negedge clk);
        checks++; if (a_o_count0 !== 8'd0) begin errors++; $display("FAIL window_outside got %0d exp 0", a_o_count0); end
        checks++; if (a_o_count1 !== 8'd2) begin errors++; $display("FAIL window_edges got %0d exp 2", a_o_count1); end
        checks++; if (a_o_count2 !== 8'd0) begin errors++; $display("FAIL window_clear got %0d exp 0", a_o_count2); end
        checks++; if (a_o_class !== 2'd1 || a_o_valid !== 1'b1) begin errors++; $display("FAIL window_class got c%0d v%0b exp c1 v1", a_o_class, a_o_valid); end
        handshake_a();
    endtask

    task automatic test_saturate;
        int k;
        s_i_net_data2 = 8'h55;
        @(negedge clk);
        s_i_valid = 1'b1;
        s_i_data0 = 8'd1; s_i_data1 = 8'd2; s_i_data2 = 8'd3;
        k = 0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            s_i_valid = 1'b0;
            if (s_o_valid) break;
        end
        checks++; if (k != 26 || s_o_valid !== 1'b1) begin errors++; $display("FAIL sat_latency got %0d exp 26", k); end
        checks++; if (s_o_count2 !== 4'd15) begin errors++; $display("FAIL sat_count2 got %0d exp 15", s_o_count2); end
        checks++; if (s_o_count0 !== 4'd0 || s_o_class !== 2'd2) begin errors++; $display("FAIL sat_class got c%0d n0 %0d exp c2 n0 0", s_o_class, s_o_count0); end
        s_i_ready = 1'b1;
        @(negedge clk);
        s_i_ready = 1'b0;
        s_i_net_data2 = 8'h00;
        checks++; if (s_o_ready !== 1'b1) begin errors++; $display("FAIL sat_idle got %0b exp 1", s_o_ready); end
    endtask

    task automatic test_hold;
        int n;
        clear_pat();
        for (int k = 0; k < 64; k++) pat[k][2] = 1'b1;
        run_a(8'd9, 8'd9, 8'd9, 1'b1);
        checks++; if (done_k != 22) begin errors++; $display("FAIL hold_latency got %0d exp 22", done_k); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_i_data0 = 8'(c);
            checks++;
            if (a_o_valid !== 1'b1 || a_o_ready !== 1'b0 || a_o_class !== 2'd2 || a_o_count2 !== 8'd16 || a_o_count0 !== 8'd0) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got v%0b r%0b c%0d n2 %0d exp v1 r0 c2 n2 16", c, a_o_valid, a_o_ready, a_o_class, a_o_count2);
            end
        end
        a_i_ready = 1'b1;
        @(negedge clk);
        a_i_ready = 1'b0;
        checks++; if (a_o_valid !== 1'b0 || a_o_ready !== 1'b1) begin errors++; $display("FAIL hold_release got v%0b r%0b exp v0 r1", a_o_valid, a_o_ready); end
        @(negedge clk);
        a_i_valid = 1'b0;
        checks++; if (a_o_ready !== 1'b0 || a_o_net_rstn !== 1'b0) begin errors++; $display("FAIL hold_reaccept got r%0b nr%0b exp r0 nr0", a_o_ready, a_o_net_rstn); end
        n = 0;
        while (a_o_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (a_o_valid !== 1'b1 || a_o_class !== 2'd2) begin errors++; $display("FAIL hold_second got v%0b c%0d exp v1 c2", a_o_valid, a_o_class); end
        handshake_a();
    endtask

    task automatic test_reset_mid;
        bit seen_valid;
        clear_pat();
        for (int k = 0; k < 64; k++) pat[k][0] = 1'b1;
        @(negedge clk);
        a_i_valid = 1'b1;
        a_i_data0 = 8'd1; a_i_data1 = 8'd1; a_i_data2 = 8'd1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            a_i_valid     = 1'b0;
            a_i_net_data0 = 8'(16 + k);
        end
        rstn = 1'b0;
        #1;
        checks++; if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0 || a_o_net_rstn !== 1'b0) begin errors++; $display("FAIL mid_ctrl got r%0b v%0b nr%0b exp r1 v0 nr0", a_o_ready, a_o_valid, a_o_net_rstn); end
        checks++; if ({a_o_net_data0, a_o_net_data1, a_o_net_data2} !== 24'h0) begin errors++; $display("FAIL mid_net_data got %0h exp 0", {a_o_net_data0, a_o_net_data1, a_o_net_data2}); end
        checks++; if (a_o_class !== 2'd0 || {a_o_count0, a_o_count1, a_o_count2} !== 24'h0) begin errors++; $display("FAIL mid_result got c%0d n %0h exp c0 n 0", a_o_class, {a_o_count0, a_o_count1, a_o_count2}); end
        seen_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (a_o_valid) seen_valid = 1'b1;
        end
        checks++; if (seen_valid) begin errors++; $display("FAIL mid_no_valid got 1 exp 0"); end
        rstn = 1'b1;
        a_i_net_data0 = 8'h00;
        @(negedge clk);
        checks++; if (a_o_net_rstn !== 1'b1 || a_o_ready !== 1'b1) begin errors++; $display("FAIL mid_release got nr%0b r%0b exp nr1 r1", a_o_net_rstn, a_o_ready); end
        clear_pat();
        for (int k = 0; k < 64; k++) pat[k][1] = 1'b1;
        run_a(8'd40, 8'd50, 8'd60, 1'b0);
        checks++; if (done_k != 22) begin errors++; $display("FAIL mid_after_latency got %0d exp 22", done_k); end
        checks++; if ({a_o_count0, a_o_count1, a_o_count2} !== {8'd0, 8'd16, 8'd0} || a_o_class !== 2'd1) begin errors++; $display("FAIL mid_after_result got %0d,%0d,%0d c%0d exp 0,16,0 c1", a_o_count0, a_o_count1, a_o_count2, a_o_class); end
        checks++; if (obs_nd[2] !== 24'h28323c) begin errors++; $display("FAIL mid_after_nd got %0h exp 28323c", obs_nd[2]); end
        handshake_a();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_window();
        test_saturate();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/snn_infer_ctrl.md
SNN_INFER_CTRL -- requirements
Module: snn_infer_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_STEPS, default 16, giving the timesteps per inference (legal 1..255).
REQ-002 The block SHALL have parameter PIPE_LAT, default 4, giving the network input-to-output latency in cycles (legal 1..15).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the spike-counter width.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port i_valid, input, 1 bit: sample offered.
REQ-007 The block SHALL have ports i_data0/1/2, input, 8 bits each: sample channels.
REQ-008 The block SHALL have port o_ready, output, 1 bit: sample accepted when i_valid && o_ready.
REQ-009 The block SHALL have port o_net_rstn, output, 1 bit: active-low state clear to the network.
REQ-010 The block SHALL have ports o_net_data0/1/2, output, 8 bits each: network input drive.
REQ-011 The block SHALL have ports i_net_data0/1/2, input, 8 bits each: network outputs.
REQ-012 The block SHALL have port o_valid, output, 1 bit: result available.
REQ-013 The block SHALL have port i_ready, input, 1 bit: result consumed when o_valid && i_ready.
REQ-014 The block SHALL have port o_class, output, 2 bits: winning output index (0..2).
REQ-015 The block SHALL have ports o_count0/1/2, output, CNT_W bits each: per-output spike counts.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, DRIVE, DRAIN and DONE; o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-017 On an accept in IDLE, the block SHALL latch i_data0..2, zero all counters, and go to CLEAR.
REQ-018 CLEAR SHALL last exactly 1 cycle, with o_net_rstn registered low only in that cycle and o_net_data all 0; the FSM then goes to DRIVE.
REQ-019 DRIVE SHALL last exactly NUM_STEPS cycles, presenting the latched sample on o_net_data0..2 every cycle; the FSM then goes to DRAIN.
REQ-020 DRAIN SHALL last exactly PIPE_LAT cycles with o_net_data = 0; the FSM then goes to DONE.
REQ-021 The count window SHALL be the last NUM_STEPS cycles of DRIVE+DRAIN combined, i.e. starting PIPE_LAT cycles after the first DRIVE cycle.
REQ-022 In every window cycle, the block SHALL increment count n by 1 when i_net_data n != 0.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 On entry to DONE, the block SHALL register o_class = argmax(count0..2), with ties resolved to the lowest index (all-zero counts give class 0).
REQ-025 In DONE, o_class and o_count0..2 SHALL be held stable until the handshake completes; i_valid and i_data SHALL be ignored.
REQ-026 On the o_valid && i_ready handshake, the FSM SHALL go to IDLE, with o_ready rising on the next cycle; there is no same-cycle bypass.
REQ-027 The total latency from accept to o_valid SHALL be exactly 1+NUM_STEPS+PIPE_LAT+1 cycles (22 with defaults).
REQ-028 i_data changes after the accept SHALL not affect the inference in progress.
REQ-029 Outside DRIVE, o_net_data0..2 SHALL be 0.

Reset
REQ-030 While i_rstn=0, the block SHALL force state IDLE, o_ready=1, o_valid=0, o_net_rstn=0, o_net_data=0, o_class=0, o_count=0, and zero the latched sample.
REQ-031 On reset mid-inference, the block SHALL discard the inference with no o_valid; after release, o_net_rstn SHALL be 1 and the block SHALL accept on the first cycle.

Structure
REQ-032 The state enum, the counter width default and the channel count (3) SHALL live in the shared package snn_pkg.
REQ-033 Argmax SHALL be one sub-module, snn_argmax3 (three CNT_W inputs, 2-bit index, lowest-index tie-break).
REQ-034 The network instance SHALL be external; the controller only drives and observes its ports.

Verification
REQ-035 Scenario: defaults, sample (10,20,30), network model gives out0 nonzero every cycle -> o_valid at cycle 22, count0=16, count1=0, count2=0, class 0.
REQ-036 Scenario: out1 spikes 5 times and out2 spikes 5 times within the window -> class 1 (tie to lower index), counts (0,5,5).
REQ-037 Scenario: CNT_W=4, NUM_STEPS=20, out2 always spiking -> count2=15 (saturated), class 2.
REQ-038 Scenario: spikes injected exactly 1 cycle before and 1 cycle after the window -> not counted; spikes on the first and last window cycle -> counted.
REQ-039 Scenario: i_ready held low 10 cycles in DONE, i_valid high throughout -> result stable, no accept, o_ready returns 1 cycle after the handshake.
REQ-040 Scenario: i_rstn asserted at DRIVE cycle 5 -> all outputs at reset values, no o_valid; new sample accepted immediately after release and completes normally.
